sd_spi_router: RTL and testbench
================================

// Module: sd_spi_router
// PURPOSE
//   Routes the core's single SPI master (DivMMC/ESXDOS-style SD port) to one of NTGT SPI targets:
//   target 0 = physical SD card pins, targets 1..NTGT-1 = virtual sd_card instances backed by
//   mounted images. Target selection changes only while the bus is idle (ss high).
//   Also generates per-target activity flags for LED_USER/LED_DISK.
//   Multi-image successor of the single-image select/activity logic in the emu wrapper.
// PARAMETERS
//   NTGT      2        number of targets, 2..8; index 0 is the physical card
//   TIMEOUT   1000000  activity hold time in clk_sys cycles after the last MOSI/MISO edge
//   MISO_REG  0        1 = register the routed miso (one cycle latency); 0 = combinational
// PORTS
//   clk_sys      in   1        system clock; all state is on its rising edge
//   reset        in   1        synchronous, active-high
//   img_mounted  in   NTGT     per-target mount strobe, 1 cycle; bit 0 is ignored
//   img_present  in   NTGT     per-target level (|img_size), sampled on img_mounted; bit 0 ignored
//   sck          in   1        master SPI clock
//   ss           in   1        master chip select, active low
//   mosi         in   1        master data out
//   miso         out  1        routed data from the selected target
//   tgt_sck      out  NTGT     per-target SPI clock
//   tgt_ss       out  NTGT     per-target chip select, active low
//   tgt_mosi     out  NTGT     per-target data
//   tgt_miso     in   NTGT     per-target data back
//   sel          out  clog2(NTGT)  currently routed target index
//   pending      out  1        1 = a different target is wanted but the switch is not yet applied
//   act          out  NTGT     per-target activity flag
// BEHAVIOUR
//   Reset values: present=0, sel=0, ss_q=1, all activity counters = TIMEOUT (act=0), miso_q=1.
//   Presence: on img_mounted[i] (i>=1), present[i] <= img_present[i]. Bit 0 is constant 0.
//   want = lowest i>=1 with present[i]=1; if none, want = 0. Combinational from registered present.
//   Switch rule: sel <= want when want!=sel AND ss==1 AND ss_q==1 (idle for >=2 consecutive cycles).
//     A switch is never applied while ss==0, so a transaction in progress is never split.
//     A mount strobe in cycle N affects want in N+1; the earliest switch is therefore N+1.
//   pending = (want != sel), combinational.
//   Routing (combinational from sel):
//     tgt_ss[i] = (sel==i) ? ss : 1
//     tgt_sck[i] = (sel==i) ? sck : 0
//     tgt_mosi[i] = (sel==i) ? mosi : 1
//   miso: MISO_REG=0 -> tgt_miso[sel]; MISO_REG=1 -> miso_q <= tgt_miso[sel], and miso = miso_q.
//   Activity: per target, counter cnt[i] of width clog2(TIMEOUT+1).
//     The edge detector registers mosi and routed tgt_miso[sel].
//     On a toggle of either while sel==i: cnt[i] <= 0. Otherwise cnt[i] increments, saturating at TIMEOUT.
//     act[i] = (cnt[i] < TIMEOUT). The counter does not wrap.
//     The counters of unselected targets keep counting.
//     On a switch, edge history is not cleared, so the first compare after a switch may flag sel's new target.
//   Reset mid-transaction: all state returns to its reset values on the next edge.
//     sel=0 immediately routes to the physical card, and all virtual tgt_ss are high.
//   Out-of-range want cannot occur (want<NTGT by construction). sel is never >= NTGT.
// TESTING
//   1. Reset, no mounts -> sel=0, pending=0, act=0. tgt_ss=all 1 except bit0=ss; miso follows tgt_miso[0].
//   2. NTGT=4, ss=1: mount strobe i=2, present=1 -> pending=1 next cycle; sel=2 on the following cycle; pending=0.
//   3. Hold ss=0, then mount i=1 -> sel stays 2 and pending=1 for all of ss low.
//      Raise ss -> sel=1 exactly 2 cycles after ss rises.
//   4. Unmount i=1 (img_present=0) and i=2 present, bus idle -> sel=2.
//      Unmount i=2 as well -> sel=0.
//   5. TIMEOUT=16, sel=1: toggle mosi once -> act[1]=1 for 16 cycles, then 0; act[0] stays 0.
//   6. MISO_REG=1: tgt_miso[sel] pulse -> miso pulse delayed by 1 cycle.
//      Assert reset with ss=0 and sel=3 -> next cycle sel=0, act=0, tgt_ss[3]=1.

Source files
------------

// File: rtl/sd_spi_router.sv
// sd_spi_router: steers one SPI master onto one of NTGT targets.
// Target 0 is the physical SD card. Targets 1..NTGT-1 are virtual cards backed by mounted images.
// The routed target changes only while the bus has been idle (ss high) for two consecutive cycles.
// Each target has an activity flag that stays set for TIMEOUT cycles after the last data edge.
module sd_spi_router #(
   parameter int NTGT     = 2,
   parameter int TIMEOUT  = 1000000,
   parameter int MISO_REG = 0,
   localparam int SW      = $clog2(NTGT),
   localparam int CW      = $clog2(TIMEOUT + 1)
) (
   input  logic            clk_sys,
   input  logic            reset,
   input  logic [NTGT-1:0] img_mounted,
   input  logic [NTGT-1:0] img_present,
   input  logic            sck,
   input  logic            ss,
   input  logic            mosi,
   output logic            miso,
   output logic [NTGT-1:0] tgt_sck,
   output logic [NTGT-1:0] tgt_ss,
   output logic [NTGT-1:0] tgt_mosi,
   input  logic [NTGT-1:0] tgt_miso,
   output logic [SW-1:0]   sel,
   output logic            pending,
   output logic [NTGT-1:0] act
);

   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   logic [NTGT-1:0] present_r;
   logic [SW-1:0]   sel_r;
   logic [SW-1:0]   want_s;
   logic            ss_q_r;
   logic            mosi_q_r;
   logic            miso_e_q_r;
   logic            miso_sel_s;
   logic            toggle_s;
   logic [CW-1:0]   cnt_r [NTGT];

   // Capture image presence on each mount strobe; the physical card slot is never "present".
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         present_r <= {NTGT{1'b0}};
      end else begin
         for (int i = 1; i < NTGT; i++) begin
            if (img_mounted[i]) begin
               present_r[i] <= img_present[i];
            end
         end
         present_r[0] <= 1'b0;
      end
   end

   // Wanted target: lowest mounted virtual card, otherwise the physical card.
   always_comb begin
      want_s = {SW{1'b0}};
      for (int i = NTGT - 1; i >= 1; i--) begin
         if (present_r[i]) begin
            want_s = SW'(i);
         end else begin
            want_s = want_s;
         end
      end
   end

   // Apply a target switch only after two consecutive idle cycles so no transaction is split.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sel_r  <= {SW{1'b0}};
         ss_q_r <= 1'b1;
      end else begin
         ss_q_r <= ss;
         if ((want_s != sel_r) && ss && ss_q_r) begin
            sel_r <= want_s;
         end
      end
   end

   assign sel     = sel_r;
   assign pending = (want_s != sel_r);

   // Route the master onto the selected target; idle levels everywhere else.
   always_comb begin
      tgt_ss   = {NTGT{1'b1}};
      tgt_sck  = {NTGT{1'b0}};
      tgt_mosi = {NTGT{1'b1}};
      tgt_ss[sel_r]   = ss;
      tgt_sck[sel_r]  = sck;
      tgt_mosi[sel_r] = mosi;
   end

   assign miso_sel_s = tgt_miso[sel_r];

   generate
      if (MISO_REG != 0) begin : g_miso_reg
         logic miso_q_r;
         // Retime the returned data by one cycle.
         always_ff @(posedge clk_sys) begin
            if (reset) begin
               miso_q_r <= 1'b1;
            end else begin
               miso_q_r <= miso_sel_s;
            end
         end
         assign miso = miso_q_r;
      end else begin : g_miso_comb
         assign miso = miso_sel_s;
      end
   endgenerate

   // Remember the previous data levels to detect toggles; history survives a target switch.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         mosi_q_r   <= 1'b1;
         miso_e_q_r <= 1'b1;
      end else begin
         mosi_q_r   <= mosi;
         miso_e_q_r <= miso_sel_s;
      end
   end

   assign toggle_s = (mosi ^ mosi_q_r) | (miso_sel_s ^ miso_e_q_r);

   // Activity hold counters: cleared by a toggle on the selected target, otherwise saturate at TIMEOUT.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         for (int i = 0; i < NTGT; i++) begin
            cnt_r[i] <= TMO;
         end
      end else begin
         for (int i = 0; i < NTGT; i++) begin
            if (toggle_s && (sel_r == SW'(i))) begin
               cnt_r[i] <= {CW{1'b0}};
            end else if (cnt_r[i] < TMO) begin
               cnt_r[i] <= cnt_r[i] + {{(CW-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // A target is active while its counter has not yet reached the hold time.
   always_comb begin
      act = {NTGT{1'b0}};
      for (int i = 0; i < NTGT; i++) begin
         act[i] = (cnt_r[i] < TMO);
      end
   end

endmodule

// File: tb/tb_sd_spi_router.sv
// Directed bench for sd_spi_router: one combinational-miso and one registered-miso instance share stimulus.
module tb_sd_spi_router;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic [3:0] img_mounted;
   logic [3:0] img_present;
   logic       sck;
   logic       ss;
   logic       mosi;
   logic [3:0] tgt_miso;

   logic       miso_a,    miso_b;
   logic [3:0] tgt_sck_a, tgt_sck_b;
   logic [3:0] tgt_ss_a,  tgt_ss_b;
   logic [3:0] tgt_mosi_a, tgt_mosi_b;
   logic [1:0] sel_a,     sel_b;
   logic       pending_a, pending_b;
   logic [3:0] act_a,     act_b;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_sys = ~clk_sys;

   sd_spi_router #(.NTGT(4), .TIMEOUT(16), .MISO_REG(0)) dut_a (
      .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_present(img_present),
      .sck(sck), .ss(ss), .mosi(mosi), .miso(miso_a),
      .tgt_sck(tgt_sck_a), .tgt_ss(tgt_ss_a), .tgt_mosi(tgt_mosi_a), .tgt_miso(tgt_miso),
      .sel(sel_a), .pending(pending_a), .act(act_a)
   );

   sd_spi_router #(.NTGT(4), .TIMEOUT(16), .MISO_REG(1)) dut_b (
      .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_present(img_present),
      .sck(sck), .ss(ss), .mosi(mosi), .miso(miso_b),
      .tgt_sck(tgt_sck_b), .tgt_ss(tgt_ss_b), .tgt_mosi(tgt_mosi_b), .tgt_miso(tgt_miso),
      .sel(sel_b), .pending(pending_b), .act(act_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check_sel(input string tag, input logic [1:0] exp_sel, input logic exp_pend);
      check({tag, " sel_a"}, 32'(sel_a), 32'(exp_sel));
      check({tag, " sel_b"}, 32'(sel_b), 32'(exp_sel));
      check({tag, " pending"}, 32'(pending_a), 32'(exp_pend));
   endtask

   initial begin
      reset = 1'b1; img_mounted = 4'b0000; img_present = 4'b0000;
      sck = 1'b0; ss = 1'b1; mosi = 1'b1; tgt_miso = 4'b1111;
      tick(); tick();
      reset = 1'b0;
      tick();

      // Reset state and routing onto the physical card
      check_sel("reset", 2'd0, 1'b0);
      check("reset act", 32'(act_a), 32'h0);
      check("reset tgt_ss", 32'(tgt_ss_a), 32'hF);
      check("reset miso_b", 32'(miso_b), 32'h1);
      ss = 1'b0; sck = 1'b1; #1;
      check("t0 tgt_ss", 32'(tgt_ss_a), 32'hE);
      check("t0 tgt_sck", 32'(tgt_sck_a), 32'h1);
      tgt_miso = 4'b1110; #1;
      check("t0 miso", 32'(miso_a), 32'h0);
      tgt_miso = 4'b1101; #1;
      check("t0 miso other", 32'(miso_a), 32'h1);
      mosi = 1'b0; #1;
      check("t0 tgt_mosi", 32'(tgt_mosi_a), 32'hE);
      tick();
      check("t0 act", 32'(act_a), 32'h1);
      ss = 1'b1; sck = 1'b0; mosi = 1'b1; tgt_miso = 4'b1111;
      for (int i = 0; i < 20; i++) tick();
      check("t0 act expired", 32'(act_a), 32'h0);

      // Mount target 2 while idle
      img_present = 4'b0100; img_mounted = 4'b0100;
      tick();
      img_mounted = 4'b0000;
      check_sel("mount2 pend", 2'd0, 1'b1);
      tick();
      check_sel("mount2 sel", 2'd2, 1'b0);

      // Mount target 1 during a transaction: no switch until two idle cycles
      ss = 1'b0;
      tick();
      img_present = 4'b0110; img_mounted = 4'b0010;
      tick();
      img_mounted = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         check_sel("busy hold", 2'd2, 1'b1);
         tick();
      end
      check("busy tgt_ss", 32'(tgt_ss_a), 32'hB);
      ss = 1'b1;
      tick();
      check_sel("ss rise +1", 2'd2, 1'b1);
      tick();
      check_sel("ss rise +2", 2'd1, 1'b0);
      sck = 1'b1; #1;
      check("t1 tgt_sck", 32'(tgt_sck_a), 32'h2);
      sck = 1'b0;

      // Unmount 1 then 2
      img_present = 4'b0000; img_mounted = 4'b0010;
      tick();
      img_mounted = 4'b0000;
      check_sel("unmount1 pend", 2'd1, 1'b1);
      tick();
      check_sel("unmount1 sel", 2'd2, 1'b0);
      img_mounted = 4'b0100;
      tick();
      img_mounted = 4'b0000;
      tick();
      check_sel("unmount2 sel", 2'd0, 1'b0);

      // Activity hold on target 1
      img_present = 4'b0010; img_mounted = 4'b0010;
      tick();
      img_mounted = 4'b0000;
      tick();
      check_sel("act sel", 2'd1, 1'b0);
      check("act idle", 32'(act_a), 32'h0);
      mosi = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         check("act hold", 32'(act_a), 32'h2);
         tick();
      end
      check("act drop", 32'(act_a), 32'h0);

      // Registered miso lags by one cycle
      tgt_miso = 4'b1101; #1;
      check("pulse miso_a", 32'(miso_a), 32'h0);
      check("pulse miso_b pre", 32'(miso_b), 32'h1);
      tick();
      check("pulse miso_b lo", 32'(miso_b), 32'h0);
      tgt_miso = 4'b1111; #1;
      check("pulse miso_b hold", 32'(miso_b), 32'h0);
      tick();
      check("pulse miso_b hi", 32'(miso_b), 32'h1);

      // Reset mid-transaction with target 3 selected
      img_present = 4'b1000; img_mounted = 4'b1010;
      tick();
      img_mounted = 4'b0000;
      tick();
      check_sel("sel3", 2'd3, 1'b0);
      ss = 1'b0;
      tick();
      check("pre-reset tgt_ss", 32'(tgt_ss_b), 32'h7);
      check("pre-reset act", 32'(act_b), 32'h2);
      reset = 1'b1;
      tick();
      check_sel("mid reset", 2'd0, 1'b0);
      check("mid reset act", 32'(act_b), 32'h0);
      check("mid reset tgt_ss", 32'(tgt_ss_b), 32'hE);
      check("mid reset miso_b", 32'(miso_b), 32'h1);
      reset = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Bound the run in case the stimulus stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
